// File: rtl/sigma_delta_mod.sv
// 2nd-order 1-bit sigma-delta modulator for the CIC interpolator output.
// The last qualified sample is held between CIC strobes. Integrators saturate
// and raise a sticky flag. Optional LFSR dither is added at the quantizer.
// In IDLE the output toggles (zero-mean 1010 pattern) and the integrators stay cleared.
//
// Handshake: data_valid qualifies data_in on the same clk edge. There is no
// backpressure; every strobed sample is taken into the hold register.
//
// Transition edges: the edge that leaves RUN still performs a full RUN
// quantizer step (dac_out, lfsr, sat_flag), but it loads zeros into the
// integrators. The edge that leaves IDLE still toggles dac_out and clears sat_flag.
module sigma_delta_mod #(
    parameter int BIT_WIDTH   = 4,
    parameter int ACC_WIDTH   = 12,
    parameter int DITHER_EN   = 0,
    parameter int DITHER_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 dac_out,
    output logic                 running,
    output logic                 sat_flag,
    output logic                 dbg_state
);

    // Extended width for the integrator sums and the quantizer input
    localparam int EW = ACC_WIDTH + 2;
    localparam logic signed [EW-1:0] FS      = EW'(2 ** (BIT_WIDTH - 1));
    localparam logic signed [EW-1:0] ACC_MAX = EW'(2 ** (ACC_WIDTH - 1) - 1);
    localparam logic signed [EW-1:0] ACC_MIN = -ACC_MAX - EW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                        r_state;
    logic signed [BIT_WIDTH-1:0]   r_x;
    logic signed [ACC_WIDTH-1:0]   r_int1;
    logic signed [ACC_WIDTH-1:0]   r_int2;
    logic [15:0]                   r_lfsr;
    logic                          r_dac;
    logic                          r_running;
    logic                          r_sat;

    logic signed [EW-1:0]          w_x_ext;
    logic signed [EW-1:0]          w_int1_ext;
    logic signed [EW-1:0]          w_int2_ext;
    logic signed [EW-1:0]          w_v;
    logic signed [EW-1:0]          w_int1_n;
    logic signed [EW-1:0]          w_int2_n;
    logic signed [EW-1:0]          w_dither;
    logic signed [EW-1:0]          w_q;
    logic signed [ACC_WIDTH-1:0]   w_int1_c;
    logic signed [ACC_WIDTH-1:0]   w_int2_c;
    logic                          w_clamp1;
    logic                          w_clamp2;
    logic                          w_lfsr_fb;

    assign w_x_ext    = {{(EW - BIT_WIDTH){r_x[BIT_WIDTH-1]}}, r_x};
    assign w_int1_ext = {{2{r_int1[ACC_WIDTH-1]}}, r_int1};
    assign w_int2_ext = {{2{r_int2[ACC_WIDTH-1]}}, r_int2};
    assign w_v        = r_dac ? FS : -FS;

    // Second integrator consumes the registered (old) first integrator
    assign w_int1_n   = w_int1_ext + w_x_ext - w_v;
    assign w_int2_n   = w_int2_ext + w_int1_ext - w_v;

    generate
        if (DITHER_EN != 0) begin : g_dither
            assign w_dither = {{(EW - DITHER_BITS){r_lfsr[DITHER_BITS-1]}},
                               r_lfsr[DITHER_BITS-1:0]};
        end else begin : g_no_dither
            assign w_dither = '0;
        end
    endgenerate

    assign w_q       = w_int2_n + w_dither;
    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Saturate both integrator updates into the accumulator range
    always_comb begin
        w_int1_c = w_int1_n[ACC_WIDTH-1:0];
        w_int2_c = w_int2_n[ACC_WIDTH-1:0];
        w_clamp1 = 1'b0;
        w_clamp2 = 1'b0;
        if (w_int1_n > ACC_MAX) begin
            w_int1_c = ACC_MAX[ACC_WIDTH-1:0];
            w_clamp1 = 1'b1;
        end else if (w_int1_n < ACC_MIN) begin
            w_int1_c = ACC_MIN[ACC_WIDTH-1:0];
            w_clamp1 = 1'b1;
        end
        if (w_int2_n > ACC_MAX) begin
            w_int2_c = ACC_MAX[ACC_WIDTH-1:0];
            w_clamp2 = 1'b1;
        end else if (w_int2_n < ACC_MIN) begin
            w_int2_c = ACC_MIN[ACC_WIDTH-1:0];
            w_clamp2 = 1'b1;
        end
    end

    // Sample hold: take every qualified CIC sample regardless of state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else if (data_valid) begin
            r_x <= data_in;
        end
    end

    // IDLE/RUN state machine with integrators, quantizer, lfsr and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_int1    <= '0;
            r_int2    <= '0;
            r_lfsr    <= 16'hACE1;
            r_dac     <= 1'b0;
            r_running <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_int1 <= '0;
                    r_int2 <= '0;
                    r_dac  <= ~r_dac;
                    if (enable) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_sat     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_dac  <= ~w_q[EW-1];
                    r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
                    if (w_clamp1 || w_clamp2) begin
                        r_sat <= 1'b1;
                    end
                    if (enable) begin
                        r_int1 <= w_int1_c;
                        r_int2 <= w_int2_c;
                    end else begin
                        r_int1    <= '0;
                        r_int2    <= '0;
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign dac_out   = r_dac;
    assign running   = r_running;
    assign sat_flag  = r_sat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sigma_delta_mod.sv
// Bench for sigma_delta_mod: three instances share one stimulus stream
// (12-bit plain, 6-bit accumulators, 12-bit with dither) and are compared
// every cycle against an integer model, plus fixed-value expectations.
module tb_sigma_delta_mod;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       vld;
  logic [3:0] din;
  logic [2:0] dac_o;
  logic [2:0] run_o;
  logic [2:0] sat_o;
  logic [2:0] dbg_o;

  int n_checks = 0;
  int n_err    = 0;
  bit rst_pulse = 0;

  // model state, index 0: ACC 12, 1: ACC 6, 2: ACC 12 + dither
  int          acc_w [3] = '{12, 6, 12};
  int          dith  [3] = '{0, 0, 1};
  longint      m_x   [3];
  longint      m_i1  [3];
  longint      m_i2  [3];
  bit          m_dac [3];
  bit          m_run [3];
  bit          m_sat [3];
  bit [15:0]   m_lfsr[3];

  sigma_delta_mod #(.BIT_WIDTH(4), .ACC_WIDTH(12), .DITHER_EN(0), .DITHER_BITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .data_in(din), .data_valid(vld),
    .dac_out(dac_o[0]), .running(run_o[0]), .sat_flag(sat_o[0]), .dbg_state(dbg_o[0]));

  sigma_delta_mod #(.BIT_WIDTH(4), .ACC_WIDTH(6), .DITHER_EN(0), .DITHER_BITS(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(en), .data_in(din), .data_valid(vld),
    .dac_out(dac_o[1]), .running(run_o[1]), .sat_flag(sat_o[1]), .dbg_state(dbg_o[1]));

  sigma_delta_mod #(.BIT_WIDTH(4), .ACC_WIDTH(12), .DITHER_EN(1), .DITHER_BITS(2)) u_dith (
    .clk(clk), .rst_n(rst_n), .enable(en), .data_in(din), .data_valid(vld),
    .dac_out(dac_o[2]), .running(run_o[2]), .sat_flag(sat_o[2]), .dbg_state(dbg_o[2]));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_range(string name, int act, int lo, int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s actual=%0d required=[%0d,%0d]", name, act, lo, hi);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_x[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
      m_dac[k] = 0; m_run[k] = 0; m_sat[k] = 0;
      m_lfsr[k] = 16'hACE1;
    end
  endfunction

  function automatic longint sat_to(longint val, longint lo, longint hi, ref bit hit);
    if (val > hi) begin hit = 1; return hi; end
    if (val < lo) begin hit = 1; return lo; end
    return val;
  endfunction

  // one clk of the modulator from the arithmetic rules; FS = 8
  function automatic void model_step(int k, bit e, bit v_in, longint x_in);
    longint lo, hi, v, n1, n2, d, c1, c2;
    bit hit;
    bit [15:0] l;
    hi = (longint'(1) << (acc_w[k] - 1)) - 1;
    lo = -hi - 1;
    if (!m_run[k]) begin
      m_i1[k] = 0;
      m_i2[k] = 0;
      m_dac[k] = !m_dac[k];
      if (e) begin m_run[k] = 1; m_sat[k] = 0; end
    end else begin
      v  = m_dac[k] ? 8 : -8;
      n1 = m_i1[k] + m_x[k] - v;
      n2 = m_i2[k] + m_i1[k] - v;
      l  = m_lfsr[k];
      d  = 0;
      if (dith[k] != 0) d = longint'(l[1:0]) - (l[1] ? 4 : 0);
      m_dac[k] = (n2 + d) >= 0;
      hit = 0;
      c1 = sat_to(n1, lo, hi, hit);
      c2 = sat_to(n2, lo, hi, hit);
      if (hit) m_sat[k] = 1;
      m_lfsr[k] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      if (e) begin
        m_i1[k] = c1; m_i2[k] = c2;
      end else begin
        m_i1[k] = 0; m_i2[k] = 0; m_run[k] = 0;
      end
    end
    if (v_in) m_x[k] = x_in;
  endfunction

  // scoreboard: advance the model at each edge, compare 1 time unit later
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (rst_pulse) begin
          model_reset();
          rst_pulse = 0;
        end
        for (int k = 0; k < 3; k++) model_step(k, en, vld, longint'($signed(din)));
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("dac_out[%0d]", k), int'(dac_o[k]), int'(m_dac[k]));
        check($sformatf("running[%0d]", k), int'(run_o[k]), int'(m_run[k]));
        check($sformatf("sat_flag[%0d]", k), int'(sat_o[k]), int'(m_sat[k]));
        check($sformatf("dbg_state[%0d]", k), int'(dbg_o[k]), int'(m_run[k]));
      end
    end
  end

  // driver tasks
  task automatic drive(bit e, bit v, logic [3:0] d);
    @(negedge clk);
    en = e; vld = v; din = d;
  endtask

  task automatic count_ones(int n, output int c0, output int c2, output int diff);
    c0 = 0; c2 = 0; diff = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c0 += int'(dac_o[0]);
      c2 += int'(dac_o[2]);
      if (dac_o[0] != dac_o[2]) diff = 1;
    end
  endtask

  initial begin
    int c0, c2, diff, got, prev, cnt;
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; din = 4'd0;
    #1;
    check("reset_dac", int'(dac_o[0]), 0);
    check("reset_running", int'(run_o[0]), 0);
    check("reset_sat", int'(sat_o[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle pattern 1,0,1,0...
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_dac_pattern", int'(dac_o[0]), (i % 2 == 0) ? 1 : 0);
      check("idle_running", int'(run_o[0]), 0);
    end

    // x = 0, plain and dithered side by side
    drive(1, 1, 4'd0);
    drive(1, 0, 4'd0);
    repeat (16) @(negedge clk);
    count_ones(256, c0, c2, diff);
    check_range("ones_x0", c0, 126, 130);
    check("sat_x0", int'(sat_o[0]), 0);
    check_range("ones_x0_dither", c2, 120, 136);
    check("dither_sequence_differs", diff, 1);

    // x = +4
    drive(1, 1, 4'd4);
    drive(1, 0, 4'd0);
    repeat (16) @(negedge clk);
    count_ones(256, c0, c2, diff);
    check_range("ones_x4", c0, 188, 196);
    check("sat_x4", int'(sat_o[0]), 0);

    // drop enable mid-RUN
    drive(0, 0, 4'd0);
    @(negedge clk);
    check("exit_running", int'(run_o[0]), 0);
    prev = int'(dac_o[0]);
    @(negedge clk);
    check("exit_dac_toggle", int'(dac_o[0]), 1 - prev);
    prev = int'(dac_o[0]);
    @(negedge clk);
    check("exit_dac_toggle2", int'(dac_o[0]), 1 - prev);

    // asynchronous reset between edges while running
    drive(1, 0, 4'd0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dac", int'(dac_o[0]), 0);
    check("async_rst_running", int'(run_o[0]), 0);
    check("async_rst_sat_acc6", int'(sat_o[1]), 0);
    #1 rst_n = 1'b1;
    rst_pulse = 1;

    // saturation with narrow accumulators, x = -8
    drive(0, 0, 4'd0);
    drive(0, 1, 4'b1000);
    drive(1, 0, 4'd0);
    got = 0;
    for (int i = 0; i < 16 && got == 0; i++) begin
      @(negedge clk);
      got = int'(sat_o[1]);
    end
    check("sat_within_16", got, 1);
    drive(0, 0, 4'd0);
    drive(1, 0, 4'd0);
    @(posedge clk);
    #1;
    check("sat_cleared_on_entry", int'(sat_o[1]), 0);

    // clear integrators, then a CIC-like strobe every 8 clk with a 0 -> 1 step
    drive(0, 1, 4'd0);
    drive(0, 0, 4'd0);
    cnt = 0;
    for (int c = 0; c < 352; c++) begin
      @(negedge clk);
      en = 1'b1;
      vld = (c % 8 == 0);
      din = (c >= 64) ? 4'd1 : 4'd0;
      if (c >= 96) cnt += int'(dac_o[0]);
    end
    check_range("ones_step_density", cnt, 139, 149);

    // randomized stimulus, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) en = ~en;
      vld = ($urandom_range(0, 3) == 0);
      din = 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
